flit_injector: RTL and testbench

FLIT_INJECTOR -- requirements
Module: flit_injector

---
 rtl/flit_injector_pkg.sv | 44 ++++
 rtl/flit_injector_fifo.sv | 58 +++++
 rtl/global.v | 18 +
 rtl/flit_injector.sv | 117 +++++++++++
 tb/tb_flit_injector.sv | 190 +++++++++++++++++++
 5 files changed

// File: rtl/flit_injector_pkg.sv
// rtl/flit_injector_pkg.sv - flit layout and port-preference helper
//
// Purpose: flit struct (MSB to LSB: rsvd, ppv, seq, pad, age, dst_x, dst_y,
// data) built from the global widths, plus the productive-port computation.
// Ports: none (package).
`include "global.v"

package flit_injector_pkg;

  localparam int DATA_W  = `WIDTH_DATA;
  localparam int COORD_W = `WIDTH_COORD;
  localparam int PPV_W   = `WIDTH_PPV;
  localparam int SEQ_W   = `WIDTH_SEQ;
  localparam int AGE_W   = `WIDTH_AGE;
  localparam int FLIT_W  = `WIDTH_INTERNAL;

  typedef struct packed {
    logic [`WIDTH_RSVD-1:0] rsvd;
    logic [PPV_W-1:0]       ppv;
    logic [SEQ_W-1:0]       seq;
    logic [`WIDTH_PAD-1:0]  pad;
    logic [AGE_W-1:0]       age;
    logic [COORD_W-1:0]     dst_x;
    logic [COORD_W-1:0]     dst_y;
    logic [DATA_W-1:0]      data;
  } flit_t;

  // ppv bits: [4] local eject, [3] N, [2] E, [1] S, [0] W
  function automatic logic [PPV_W-1:0] calc_ppv(
    input logic [COORD_W-1:0] dx,
    input logic [COORD_W-1:0] dy,
    input logic [COORD_W-1:0] lx,
    input logic [COORD_W-1:0] ly
  );
    logic [PPV_W-1:0] p;
    p[4] = (dx == lx) && (dy == ly);
    p[3] = dy > ly;
    p[2] = dx > lx;
    p[1] = dy < ly;
    p[0] = dx < lx;
    return p;
  endfunction

endpackage

// File: rtl/flit_injector_fifo.sv
// rtl/flit_injector_fifo.sv - circular flit queue (module inj_fifo)
//
// Purpose: DEPTH-entry FIFO holding flits; exposes its pointers so the
// injector can keep per-slot side state (ages) aligned with the storage.
// Ports:
//   clk, reset          - clock, synchronous active-high reset
//   push, push_data     - write push_data at tail
//   pop                 - retire head entry
//   head_data           - entry at head (undefined when count==0)
//   head_ptr, tail_ptr  - current slot indices
//   count               - number of valid entries (0..DEPTH)
`include "global.v"

module inj_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 64,
  localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic [W-1:0]  push_data,
  input  logic          pop,
  output logic [W-1:0]  head_data,
  output logic [PW-1:0] head_ptr,
  output logic [PW-1:0] tail_ptr,
  output logic [4:0]    count
);

  logic [W-1:0] mem [DEPTH];

  // Storage is not reset; entries are only visible through count.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[tail_ptr] <= push_data;
    end
  end

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge clk) begin
    if (reset) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      count    <= '0;
    end else begin
      if (push) tail_ptr <= tail_ptr + 1'b1;
      if (pop)  head_ptr <= head_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 5'd1;
        2'b01:   count <= count - 5'd1;
        default: count <= count;
      endcase
    end
  end

  assign head_data = mem[head_ptr];

endmodule

// File: rtl/global.v
// rtl/global.v - shared flit field widths and sizes for the NoC injector
//
// Purpose: single source of truth for flit field widths. Guarded so it can be
// included by every file that needs the widths.
// Ports: none (macro definitions only).
`ifndef GLOBAL_V
`define GLOBAL_V

`define WIDTH_DATA     32
`define WIDTH_COORD    4
`define WIDTH_PPV      5
`define WIDTH_SEQ      6
`define WIDTH_AGE      8
`define WIDTH_RSVD     3
`define WIDTH_PAD      2
`define WIDTH_INTERNAL (`WIDTH_RSVD + `WIDTH_PPV + `WIDTH_SEQ + `WIDTH_PAD + `WIDTH_AGE + 2*`WIDTH_COORD + `WIDTH_DATA)

`endif

// File: rtl/flit_injector.sv
// rtl/flit_injector.sv - NoC flit injector: packet to flit queue toward router
//
// Purpose: accepts packets from the core, tags them with productive-port
// vector and sequence number, queues them, and offers the head flit whenever
// the router reports a free input slot. Optional macro INJ_AGE_EN enables
// per-entry saturating age counters; otherwise the age field is constant 0.
// Ports:
//   clk, reset                    - clock, synchronous active-high reset
//   pkt_valid/pkt_ready           - packet handshake from the core
//   pkt_dst_x, pkt_dst_y, pkt_data- packet destination and payload
//   slot_free                     - router can take a flit this cycle
//   inj_valid, inj_flit           - head flit offered to the router
//   occupancy                     - number of queued entries
`include "global.v"

module flit_injector
  import flit_injector_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int LOCAL_X = 0,
  parameter int LOCAL_Y = 0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       pkt_valid,
  output logic                       pkt_ready,
  input  logic [`WIDTH_COORD-1:0]    pkt_dst_x,
  input  logic [`WIDTH_COORD-1:0]    pkt_dst_y,
  input  logic [`WIDTH_DATA-1:0]     pkt_data,
  input  logic                       slot_free,
  output logic                       inj_valid,
  output logic [`WIDTH_INTERNAL-1:0] inj_flit,
  output logic [4:0]                 occupancy
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic             push;
  logic             pop;
  logic [SEQ_W-1:0] seq_q;
  logic [AGE_W-1:0] head_age;
  logic [PW-1:0]    head_ptr;
  logic [PW-1:0]    tail_ptr;
  flit_t            push_flit;
  flit_t            head_flit;
  flit_t            out_flit;

  // Ready depends only on occupancy so it never combinationally follows slot_free.
  assign pkt_ready = occupancy < 5'(DEPTH);
  assign inj_valid = occupancy != 5'd0;
  assign push      = pkt_valid && pkt_ready;
  assign pop       = inj_valid && slot_free;

  always_comb begin
    push_flit       = '0;
    push_flit.ppv   = calc_ppv(pkt_dst_x, pkt_dst_y, 4'(LOCAL_X), 4'(LOCAL_Y));
    push_flit.seq   = seq_q;
    push_flit.dst_x = pkt_dst_x;
    push_flit.dst_y = pkt_dst_y;
    push_flit.data  = pkt_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      seq_q <= '0;
    end else if (push) begin
      seq_q <= seq_q + 1'b1;
    end
  end

  inj_fifo #(
    .DEPTH (DEPTH),
    .W     (FLIT_W)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (push_flit),
    .pop       (pop),
    .head_data (head_flit),
    .head_ptr  (head_ptr),
    .tail_ptr  (tail_ptr),
    .count     (occupancy)
  );

`ifdef INJ_AGE_EN
  logic [AGE_W-1:0] age_q [DEPTH];

  // Every slot ages each cycle; free slots are harmless because the push
  // clears the slot's age. A popped entry leaves, so "not popped" holds.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) age_q[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (age_q[i] != '1) age_q[i] <= age_q[i] + 1'b1;
      end
      if (push) age_q[tail_ptr] <= '0;
    end
  end

  assign head_age = age_q[head_ptr];
`else
  logic unused_ptrs;
  assign unused_ptrs = ^{head_ptr, tail_ptr};
  assign head_age    = '0;
`endif

  always_comb begin
    out_flit     = head_flit;
    out_flit.age = head_age;
    if (!inj_valid) out_flit = '0;
  end

  assign inj_flit = out_flit;

endmodule

// File: tb/tb_flit_injector.sv
// tb/tb_flit_injector.sv - scoreboard bench for flit_injector
`include "global.v"

module tb_flit_injector;
  import flit_injector_pkg::*;

  localparam int DEPTH = 4;
  localparam int LX    = 1;
  localparam int LY    = 1;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              pkt_valid = 1'b0;
  logic              pkt_ready;
  logic [3:0]        pkt_dst_x = '0;
  logic [3:0]        pkt_dst_y = '0;
  logic [DATA_W-1:0] pkt_data = '0;
  logic              slot_free = 1'b0;
  logic              inj_valid;
  logic [FLIT_W-1:0] inj_flit;
  logic [4:0]        occupancy;

  flit_injector #(
    .DEPTH   (DEPTH),
    .LOCAL_X (LX),
    .LOCAL_Y (LY)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .pkt_valid (pkt_valid),
    .pkt_ready (pkt_ready),
    .pkt_dst_x (pkt_dst_x),
    .pkt_dst_y (pkt_dst_y),
    .pkt_data  (pkt_data),
    .slot_free (slot_free),
    .inj_valid (inj_valid),
    .inj_flit  (inj_flit),
    .occupancy (occupancy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int                dx;
    int                dy;
    logic [DATA_W-1:0] data;
    int                seq;
    int                born;
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;
  int   seq_model = 0;
  bit   mon_en = 0;

  function automatic logic [4:0] ref_ppv(int dx, int dy);
    logic [4:0] p;
    p[4] = (dx == LX) && (dy == LY);
    p[3] = dy > LY;
    p[2] = dx > LX;
    p[1] = dy < LY;
    p[0] = dx < LX;
    return p;
  endfunction

  function automatic logic [FLIT_W-1:0] ref_flit(exp_t e, int now);
    logic [7:0] a;
    int d;
    d = now - e.born;
`ifdef INJ_AGE_EN
    a = (d > 255) ? 8'd255 : d[7:0];
`else
    a = 8'd0;
`endif
    return {3'b000, ref_ppv(e.dx, e.dy), 6'(e.seq), 2'b00, a, 4'(e.dx), 4'(e.dy), e.data};
  endfunction

  task automatic check(string name, logic [FLIT_W-1:0] act, logic [FLIT_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at cycle %0d: actual=%h expected=%h", name, cyc, act, exp);
    end
  endtask

  // Monitor: compares DUT against the model every cycle, pops on injection.
  always begin
    @(negedge clk);
    #2;
    if (mon_en) begin
      check("occupancy", 64'(occupancy), 64'(q.size()));
      check("pkt_ready", 64'(pkt_ready), 64'(q.size() < DEPTH));
      check("inj_valid", 64'(inj_valid), 64'(q.size() != 0));
      if (q.size() == 0) begin
        check("empty_flit", inj_flit, '0);
      end else begin
        check("head_flit", inj_flit, ref_flit(q[0], cyc));
        if (slot_free && !reset) void'(q.pop_front());
      end
    end
  end

  // One clock of stimulus; dx/dy < 0 selects a random destination.
  task automatic cycle(bit v, bit sf, int dx = -1, int dy = -1);
    bit   do_push;
    exp_t e;
    @(negedge clk);
    reset = 1'b0;
    e.dx = (dx >= 0) ? dx : ($urandom_range(0, 1) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 2)));
    e.dy = (dy >= 0) ? dy : ($urandom_range(0, 1) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 2)));
    e.data = DATA_W'($urandom);
    pkt_valid = v;
    pkt_dst_x = 4'(e.dx);
    pkt_dst_y = 4'(e.dy);
    pkt_data  = e.data;
    slot_free = sf;
    do_push = v && (q.size() < DEPTH);
    @(posedge clk);
    #1;
    if (do_push) begin
      e.seq  = seq_model;
      e.born = cyc;
      q.push_back(e);
      seq_model = (seq_model + 1) % 64;
    end
  endtask

  // Two reset cycles with the core still offering packets.
  task automatic do_reset();
    repeat (2) begin
      @(negedge clk);
      reset     = 1'b1;
      pkt_valid = 1'b1;
      slot_free = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
      q.delete();
      seq_model = 0;
      mon_en    = 1;
    end
  endtask

  initial begin
    do_reset();

    // Single packet to (3,2) from (1,1): ppv 01100, seq 0, age 0.
    cycle(1, 1, 3, 2);
    cycle(0, 1);
    cycle(0, 0);

    // Fill to full with router blocked, let ages grow, then full+slot_free.
    repeat (DEPTH) cycle(1, 0);
    repeat (3) cycle(1, 0);
    cycle(1, 1);
    cycle(1, 0);
    repeat (DEPTH + 2) cycle(0, 1);

    // Age saturation on a long-held entry.
    do_reset();
    cycle(1, 0, 1, 1);
    repeat (300) cycle(0, 0);
    cycle(0, 1);
    cycle(0, 0);

    // Sequence wrap: 70 back-to-back push/pop cycles.
    do_reset();
    repeat (70) cycle(1, 1);
    repeat (DEPTH + 2) cycle(0, 1);

    // Reset with entries queued discards them; next seq restarts at 0.
    repeat (3) cycle(1, 0);
    do_reset();
    cycle(1, 1, 0, 0);
    cycle(0, 1);

    // Random traffic.
    repeat (3000) cycle($urandom_range(0, 99) < 60, $urandom_range(0, 99) < 50);
    repeat (DEPTH + 2) cycle(0, 1);

    @(negedge clk);
    #3;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
